// File: rtl/sisc_ctrl.sv
// sisc_ctrl - multi-cycle control unit for the SISC processor.
//
// Steps the datapath through START0/START1 once after reset, then through
// FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK for every instruction.
// All outputs are decoded combinationally from the state register and the
// instruction fields. Conditional branches are resolved in DECODE against
// the latched CVNZ status.
//
// Ports:
//   clk        system clock
//   rst_f      asynchronous active-low reset
//   opcode     ir[31:28]
//   mm         ir[27:24] branch condition mask (C,V,N,Z)
//   stat       status register contents (C,V,N,Z)
//   pc_rst     clear PC
//   pc_write   load PC
//   pc_sel     0 = PC+1, 1 = branch target
//   br_sel     0 = absolute target, 1 = PC-relative target
//   ir_load    load instruction register
//   rb_sel     read-port B addresses rd (store data)
//   alu_op     ALU override: 00 reg arith, 01 imm arith, 11 imm non-arith,
//              10 non-arith
//   dm_we      data memory write enable
//   wb_sel     0 = ALU result, 1 = memory data to register file
//   rf_we      register file write enable
//   halt       processor halted
//   illegal    undefined opcode trapped (only with SISC_CTRL_TRAP_EN)
//
// Build option: define SISC_CTRL_TRAP_EN to halt on undefined opcodes and
// flag them on the illegal output; otherwise they execute as NOP.

module sisc_ctrl #(
  parameter int OP_W = 4,
  parameter int MM_W = 4
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [OP_W-1:0] opcode,
  input  logic [MM_W-1:0] mm,
  input  logic [MM_W-1:0] stat,
  output logic            pc_rst,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            br_sel,
  output logic            ir_load,
  output logic            rb_sel,
  output logic [1:0]      alu_op,
  output logic            dm_we,
  output logic            wb_sel,
  output logic            rf_we,
`ifdef SISC_CTRL_TRAP_EN
  output logic            illegal,
`endif
  output logic            halt
);

  // state     | meaning
  // ----------+----------------------------------------------------
  // START0    | reset held / just released, PC cleared
  // START1    | PC settles, no activity
  // FETCH     | load IR, advance PC
  // DECODE    | resolve branches, detect HLT
  // EXECUTE   | ALU operates; its result and flags latch at cycle end
  // MEM       | store writes data memory
  // WRITEBACK | register file write for ALU ops and loads
  // HALT      | stopped until reset
  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ALU = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_ADI = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_BRA = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_BRR = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_BNR = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_LOD = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_STR = OP_W'(4'h9);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  localparam logic [1:0] ALU_REG    = 2'b00;
  localparam logic [1:0] ALU_IMM    = 2'b01;
  localparam logic [1:0] ALU_IMM_NA = 2'b11;
  localparam logic [1:0] ALU_NA     = 2'b10;

  state_t state_q, state_d;

  logic hit;
  logic mask_zero;
  logic op_defined;

  assign hit       = |(mm & stat);
  assign mask_zero = (mm == '0);

  always_comb begin
    op_defined = 1'b0;
    case (opcode)
      OP_NOP, OP_ALU, OP_ADI, OP_BRA, OP_BRR, OP_BNE, OP_BNR,
      OP_LOD, OP_STR, OP_HLT: op_defined = 1'b1;
      default:                op_defined = 1'b0;
    endcase
  end

`ifdef SISC_CTRL_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`endif

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= S_START0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    rb_sel   = 1'b0;
    alu_op   = ALU_NA;
    dm_we    = 1'b0;
    wb_sel   = 1'b0;
    rf_we    = 1'b0;
    halt     = 1'b0;
`ifdef SISC_CTRL_TRAP_EN
    illegal_d = illegal_q;
`endif

    case (state_q)
      S_START0: begin
        pc_rst  = 1'b1;
        state_d = S_START1;
      end

      S_START1: state_d = S_FETCH;

      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        pc_sel   = 1'b0;
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        state_d = S_EXECUTE;
        case (opcode)
          OP_HLT: state_d = S_HALT;
          // An empty mask makes BRA/BRR unconditional and BNE/BNR never taken.
          OP_BRA, OP_BRR: begin
            if (hit || mask_zero) begin
              pc_write = 1'b1;
              pc_sel   = 1'b1;
              br_sel   = (opcode == OP_BRR);
            end
          end
          OP_BNE, OP_BNR: begin
            if (!hit && !mask_zero) begin
              pc_write = 1'b1;
              pc_sel   = 1'b1;
              br_sel   = (opcode == OP_BNR);
            end
          end
          default: ;
        endcase
`ifdef SISC_CTRL_TRAP_EN
        if (!op_defined) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
`endif
      end

      S_EXECUTE: begin
        state_d = S_MEM;
        case (opcode)
          OP_ALU:         alu_op = ALU_REG;
          OP_ADI:         alu_op = ALU_IMM;
          OP_LOD, OP_STR: alu_op = ALU_IMM_NA;
          default:        alu_op = ALU_NA;
        endcase
        rb_sel = (opcode == OP_STR);
      end

      // Keep the address calculation stable through the store cycle without
      // re-touching the flags.
      S_MEM: begin
        state_d = S_WRITEBACK;
        if (opcode == OP_STR) begin
          dm_we  = 1'b1;
          rb_sel = 1'b1;
          alu_op = ALU_IMM_NA;
        end
      end

      S_WRITEBACK: begin
        state_d = S_FETCH;
        if (opcode == OP_ALU || opcode == OP_ADI) begin
          rf_we  = 1'b1;
          wb_sel = 1'b0;
        end else if (opcode == OP_LOD) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end
      end

      S_HALT: halt = 1'b1;

      default: state_d = S_START0;
    endcase
  end

  // Only the trap build consumes the defined-opcode decode.
  logic unused_ok;
  assign unused_ok = op_defined;

endmodule
